// File: rtl/elevator_scheduler_if.sv
// Bus between the car controller/datapath and the elevator scheduler.
interface elevator_scheduler_if;
  logic [3:0] car_call;
  logic [2:0] hall_up;      // bit n = floor n (floors 0-2)
  logic [2:0] hall_down;    // bit n = floor n+1 (floors 1-3)
  logic [1:0] cur_floor;
  logic       arrived;
  logic       door_sensor;
  logic       door_hold;
  logic       move_up;
  logic       move_down;
  logic       door_open;
  logic [1:0] target_floor;
  logic [3:0] pending;

  modport master (
    output car_call, hall_up, hall_down, cur_floor, arrived, door_sensor, door_hold,
    input  move_up, move_down, door_open, target_floor, pending
  );

  modport slave (
    input  car_call, hall_up, hall_down, cur_floor, arrived, door_sensor, door_hold,
    output move_up, move_down, door_open, target_floor, pending
  );
endinterface

// File: rtl/elevator_scheduler.sv
// Four-floor elevator scheduler: sticky request latching, directional
// collective control (IDLE/UP/DOWN/DOOR) and door dwell timing.
module elevator_scheduler #(
  parameter int unsigned DWELL_CT = 2
) (
  input logic           clk,
  input logic           reset,
  elevator_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StUp, StDown, StDoor} state_e;
  typedef enum logic [1:0] {DirNone, DirUp, DirDown} dir_e;

  localparam logic [3:0] DwellMax = 4'(DWELL_CT);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [3:0] cc_q, cc_d;
  logic [2:0] hu_q, hu_d;
  logic [2:0] hd_q, hd_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] tgt_q, tgt_d;

  logic [3:0] up_f, dn_f, req_f, here;
  logic [1:0] cur;
  logic       at, above, below, beyond, opposite;
  logic       up_hit, dn_hit;
  logic [1:0] up_flr, dn_flr;

  // Per-floor view of the latched requests relative to the car position.
  always_comb begin
    cur    = bus.cur_floor;
    up_f   = {1'b0, hu_q};
    dn_f   = {hd_q, 1'b0};
    req_f  = cc_q | up_f | dn_f;
    here   = 4'b0001 << cur;
    at     = |(req_f & here);
    above  = 1'b0;
    below  = 1'b0;
    up_hit = 1'b0;
    dn_hit = 1'b0;
    up_flr = cur;
    dn_flr = cur;
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(cur) && req_f[i]) above = 1'b1;
      // Descending scan: the lowest pending floor at or above cur wins.
      if (i >= int'(cur) && req_f[i]) begin
        up_hit = 1'b1;
        up_flr = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i < int'(cur) && req_f[i]) below = 1'b1;
      if (i <= int'(cur) && req_f[i]) begin
        dn_hit = 1'b1;
        dn_flr = 2'(i);
      end
    end
    beyond   = (dir_q == DirUp) ? above : (dir_q == DirDown) ? below : 1'b0;
    opposite = (dir_q == DirUp) ? below : (dir_q == DirDown) ? above : 1'b0;
  end

  logic [2:0] sup_hu, sup_hd;
  logic [3:0] blk_cc;
  logic [2:0] blk_hu, blk_hd;
  logic       in_door, restart, entry;

  // Requests served at this floor: cleared on door entry, refused while the door is open.
  always_comb begin
    sup_hu  = ((dir_q != DirDown) || !beyond) ? here[2:0] : 3'b000;
    sup_hd  = ((dir_q != DirUp) || !beyond) ? here[3:1] : 3'b000;
    in_door = (state_q == StDoor);
    blk_cc  = in_door ? (bus.car_call & here) : 4'b0000;
    blk_hu  = in_door ? (bus.hall_up & sup_hu) : 3'b000;
    blk_hd  = in_door ? (bus.hall_down & sup_hd) : 3'b000;
    restart = |{blk_cc, blk_hu, blk_hd};
  end

  // Next-state, direction and dwell counter.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (at) begin
          state_d = StDoor;
        end else if (above) begin
          state_d = StUp;
          dir_d   = DirUp;
        end else if (below) begin
          state_d = StDown;
          dir_d   = DirDown;
        end
      end
      StUp: begin
        if (bus.arrived && (cc_q[cur] || up_f[cur] || (dn_f[cur] && !above) || cur == 2'd3)) begin
          state_d = StDoor;
        end
      end
      StDown: begin
        if (bus.arrived && (cc_q[cur] || dn_f[cur] || (up_f[cur] && !below) || cur == 2'd0)) begin
          state_d = StDoor;
        end
      end
      StDoor: begin
        if (bus.door_sensor || bus.door_hold || restart) begin
          cnt_d = 4'd0;
        end else if (cnt_q != DwellMax) begin
          cnt_d = cnt_q + 4'd1;
        end else if (beyond || opposite) begin
          // Continue if work lies ahead, otherwise turn around.
          if ((dir_q == DirUp) == beyond) begin
            state_d = StUp;
            dir_d   = DirUp;
          end else begin
            state_d = StDown;
            dir_d   = DirDown;
          end
        end else begin
          state_d = StIdle;
          dir_d   = DirNone;
        end
      end
      default: state_d = StIdle;
    endcase
    entry = (state_d == StDoor) && !in_door;
    if (entry) cnt_d = 4'd0;
  end

  // Sticky request registers and the registered target floor.
  always_comb begin
    cc_d = cc_q | (bus.car_call & ~blk_cc);
    hu_d = hu_q | (bus.hall_up & ~blk_hu);
    hd_d = hd_q | (bus.hall_down & ~blk_hd);
    if (entry) begin
      cc_d = cc_d & ~here;
      hu_d = hu_d & ~sup_hu;
      hd_d = hd_d & ~sup_hd;
    end
    unique case (dir_q)
      DirUp:   tgt_d = up_hit ? up_flr : cur;
      DirDown: tgt_d = dn_hit ? dn_flr : cur;
      // Inclusive upward scan gives at-floor, then above, then below priority.
      default: tgt_d = up_hit ? up_flr : (dn_hit ? dn_flr : cur);
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      dir_q   <= DirNone;
      cc_q    <= 4'b0000;
      hu_q    <= 3'b000;
      hd_q    <= 3'b000;
      cnt_q   <= 4'd0;
      tgt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cc_q    <= cc_d;
      hu_q    <= hu_d;
      hd_q    <= hd_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign bus.move_up      = (state_q == StUp);
  assign bus.move_down    = (state_q == StDown);
  assign bus.door_open    = (state_q == StDoor);
  assign bus.target_floor = tgt_q;
  assign bus.pending      = req_f;

endmodule
